// File: rtl/nand_flash_array.sv
// nand_flash_array: behavioural NAND array with page buffer, erase/program/read FSM and
// busy timing. Bits only ever move 1->0 on program; erase restores a whole block to ones.
module nand_flash_array #(
    parameter int DATA_W    = 8,
    parameter int BLOCKS    = 8,
    parameter int PAGES     = 8,
    parameter int PAGE_SIZE = 16,
    parameter int T_PROG    = 20,
    parameter int T_ERASE   = 50,
    parameter int T_READ    = 5,
    localparam int BW = BLOCKS > 1 ? $clog2(BLOCKS) : 1,
    localparam int PW = PAGES > 1 ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [BW-1:0]     blk,
    input  logic [PW-1:0]     page,
    input  logic              wp_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              fail
);
    localparam int IW = PAGE_SIZE > 1 ? $clog2(PAGE_SIZE) : 1;
    localparam int NP = BLOCKS * PAGES;
    localparam int AW = NP > 1 ? $clog2(NP) : 1;
    localparam int LW = PAGE_SIZE * DATA_W;
    localparam int TM = T_ERASE > T_PROG ? (T_ERASE > T_READ ? T_ERASE : T_READ)
                                         : (T_PROG > T_READ ? T_PROG : T_READ);
    localparam int CW = $clog2(TM + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PROG, ERASE, TREAD, STREAM} state_t;

    state_t          state;
    logic [BW-1:0]   blk_r;
    logic [PW-1:0]   page_r;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [LW-1:0]   pbuf;
    // Pages are stored inverted so the power-up all-zero contents read back as erased.
    logic [LW-1:0]   mem_n [NP];
    logic [AW-1:0]   pa;
    logic [AW-1:0]   base;
    logic [LW-1:0]   old;
    logic            oob;
    logic            reject;
    logic            last;

    assign base      = AW'(blk_r) * AW'(PAGES);
    assign pa        = base + AW'(page_r);
    assign old       = ~mem_n[pa];
    assign oob       = int'(blk) >= BLOCKS || int'(page) >= PAGES;
    assign reject    = oob || (!wp_n && (cmd == 2'b01 || cmd == 2'b10));
    assign last      = idx == IW'(PAGE_SIZE - 1);
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign wr_ready  = state == LOAD;
    assign rd_valid  = state == STREAM;
    assign rd_data   = rd_valid ? pbuf[idx*DATA_W +: DATA_W] : '0;
    assign rd_last   = rd_valid && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            blk_r  <= '0;
            page_r <= '0;
            cnt    <= '0;
            idx    <= '0;
            done   <= 1'b0;
            fail   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    blk_r  <= blk;
                    page_r <= page;
                    idx    <= '0;
                    if (reject) begin
                        fail <= 1'b1;
                        done <= 1'b1;
                    end else if (cmd == 2'b00) begin
                        fail <= 1'b0;
                        done <= 1'b1;
                    end else if (cmd == 2'b01) begin
                        state <= ERASE;
                        cnt   <= CW'(T_ERASE - 1);
                    end else if (cmd == 2'b10) begin
                        state <= LOAD;
                    end else begin
                        state <= TREAD;
                        cnt   <= CW'(T_READ - 1);
                    end
                end
                LOAD: if (wr_valid) begin
                    idx <= idx + 1'b1;
                    if (last) begin
                        state <= PROG;
                        cnt   <= CW'(T_PROG - 1);
                    end
                end
                PROG: if (cnt == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (|(~old & pbuf)) fail <= 1'b1;
                end else cnt <= cnt - 1'b1;
                ERASE: if (cnt == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else cnt <= cnt - 1'b1;
                TREAD: if (cnt == '0) begin
                    state <= STREAM;
                    idx   <= '0;
                end else cnt <= cnt - 1'b1;
                STREAM: if (rd_ready) begin
                    idx <= idx + 1'b1;
                    if (last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array and page buffer carry no reset: the array is non-volatile.
    always_ff @(posedge clk) begin
        if (state == LOAD && wr_valid) pbuf[idx*DATA_W +: DATA_W] <= wr_data;
        if (state == TREAD && cnt == '0) pbuf <= old;
        if (state == PROG && cnt == '0) mem_n[pa] <= mem_n[pa] | ~pbuf;
        if (state == ERASE && cnt == '0)
            for (int p = 0; p < PAGES; p++) mem_n[base + AW'(p)] <= '0;
    end
endmodule
